vram_port_arbiter: RTL and testbench

- Parametrised successor to the single-client VRAM strobe logic at the top level.
- Arbitrates NUM_PORTS independent request/acknowledge clients (VDP, CPU direct access, super-res fetch, and so on) plus a periodic refresh onto one MEM_CONTROLLER read/write/refresh/busy interface.
- Grants are round-robin, one access in flight at a time.
- Read data is returned to the granted port with a valid pulse.

---
 rtl/vram_port_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_vram_port_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_port_arbiter.sv
// Round-robin arbiter multiplexing NUM_PORTS VRAM clients plus periodic refresh
// onto a single read/write/refresh/busy memory-controller interface.
module vram_port_arbiter #(
  parameter int NUM_PORTS        = 4,
  parameter int ADDR_WIDTH       = 17,
  parameter int DATA_WIDTH       = 32,
  parameter int REFRESH_INTERVAL = 1024
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_PORTS-1:0]             port_req,
  input  logic [NUM_PORTS-1:0]             port_wr,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  port_addr,
  input  logic [NUM_PORTS*2-1:0]           port_size,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  port_din,
  output logic [NUM_PORTS-1:0]             port_ack,
  output logic [NUM_PORTS-1:0]             port_rvalid,
  output logic [DATA_WIDTH-1:0]            port_dout,
  output logic                             mem_read,
  output logic                             mem_write,
  output logic                             mem_refresh,
  input  logic                             mem_busy,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_din,
  output logic [1:0]                       mem_size,
  input  logic [DATA_WIDTH-1:0]            mem_dout,
  output logic                             refresh_overrun
);

  localparam int unsigned NP = NUM_PORTS;
  localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW = $clog2(REFRESH_INTERVAL);

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_ISSUE      = 2'd1;
  localparam logic [1:0] S_WAIT_START = 2'd2;
  localparam logic [1:0] S_WAIT_DONE  = 2'd3;

  logic [1:0]            r_state;
  logic [GW-1:0]         r_grant;
  logic [GW-1:0]         r_last;
  logic                  r_wr;
  logic                  r_is_ref;
  logic [CW-1:0]         r_rcnt;
  logic                  r_pend;
  logic                  r_ovr;
  logic [NUM_PORTS-1:0]  r_ack;
  logic [NUM_PORTS-1:0]  r_rvalid;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_rd_stb;
  logic                  r_wr_stb;
  logic                  r_ref_stb;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_din;
  logic [1:0]            r_mem_size;

  logic                  w_expire;
  logic                  w_refresh_due;
  logic                  w_refresh_take;
  logic [NUM_PORTS-1:0]  w_req;
  logic                  w_pick_valid;
  logic [GW-1:0]         w_pick;
  logic [GW-1:0]         w_cand;
  int unsigned           w_idx;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_din;
  logic [1:0]            w_sel_size;
  logic                  w_sel_wr;

  assign w_expire       = (r_rcnt == '0);
  // An expiry in the same cycle as an idle decision is served immediately.
  assign w_refresh_due  = r_pend | w_expire;
  assign w_refresh_take = (r_state == S_IDLE) && !mem_busy && w_refresh_due;
  // A client sees its ack one edge late, so its still-high req is ignored then.
  assign w_req          = port_req & ~r_ack;

  always_comb begin
    w_pick_valid = 1'b0;
    w_pick       = '0;
    w_cand       = '0;
    w_idx        = 0;
    for (int unsigned k = 1; k <= NP; k++) begin
      w_idx = 32'(r_last) + k;
      if (w_idx >= NP) w_idx = w_idx - NP;
      w_cand = GW'(w_idx);
      if (!w_pick_valid && w_req[w_cand]) begin
        w_pick_valid = 1'b1;
        w_pick       = w_cand;
      end
    end
  end

  always_comb begin
    w_sel_addr = '0;
    w_sel_din  = '0;
    w_sel_size = '0;
    w_sel_wr   = 1'b0;
    for (int unsigned i = 0; i < NP; i++) begin
      if (w_pick == GW'(i)) begin
        w_sel_addr = port_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_din  = port_din[i*DATA_WIDTH +: DATA_WIDTH];
        w_sel_size = port_size[i*2 +: 2];
        w_sel_wr   = port_wr[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rcnt <= CW'(REFRESH_INTERVAL - 1);
      r_pend <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      r_rcnt <= w_expire ? CW'(REFRESH_INTERVAL - 1) : r_rcnt - CW'(1);
      r_pend <= w_refresh_due & ~w_refresh_take;
      if (w_expire && r_pend) r_ovr <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_last     <= GW'(NUM_PORTS - 1);
      r_wr       <= 1'b0;
      r_is_ref   <= 1'b0;
      r_ack      <= '0;
      r_rvalid   <= '0;
      r_dout     <= '0;
      r_rd_stb   <= 1'b0;
      r_wr_stb   <= 1'b0;
      r_ref_stb  <= 1'b0;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
      r_mem_size <= '0;
    end else begin
      r_ack     <= '0;
      r_rvalid  <= '0;
      r_rd_stb  <= 1'b0;
      r_wr_stb  <= 1'b0;
      r_ref_stb <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_refresh_take) begin
            r_ref_stb <= 1'b1;
            r_is_ref  <= 1'b1;
            r_state   <= S_WAIT_START;
          end else if (!mem_busy && w_pick_valid) begin
            r_is_ref   <= 1'b0;
            r_grant    <= w_pick;
            r_last     <= w_pick;
            r_wr       <= w_sel_wr;
            r_mem_addr <= w_sel_addr;
            r_mem_din  <= w_sel_din;
            r_mem_size <= w_sel_size;
            r_rd_stb   <= ~w_sel_wr;
            r_wr_stb   <= w_sel_wr;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: r_state <= S_WAIT_START;
        S_WAIT_START: begin
          if (mem_busy) r_state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (!mem_busy) begin
            if (!r_is_ref) begin
              r_ack[r_grant] <= 1'b1;
              if (!r_wr) begin
                r_rvalid[r_grant] <= 1'b1;
                r_dout            <= mem_dout;
              end
            end
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign port_ack        = r_ack;
  assign port_rvalid     = r_rvalid;
  assign port_dout       = r_dout;
  assign mem_read        = r_rd_stb;
  assign mem_write       = r_wr_stb;
  assign mem_refresh     = r_ref_stb;
  assign mem_addr        = r_mem_addr;
  assign mem_din         = r_mem_din;
  assign mem_size        = r_mem_size;
  assign refresh_overrun = r_ovr;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Self-checking bench for vram_port_arbiter: transaction-level reference model
// compared every cycle, plus directed scenarios with hand-computed expectations.
module tb_vram_port_arbiter;

  localparam int NP = 4;
  localparam int AW = 17;
  localparam int DW = 32;
  localparam int RI = 16;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NP-1:0]     port_req = '0;
  logic [NP-1:0]     port_wr = '0;
  logic [NP*AW-1:0]  port_addr = '0;
  logic [NP*2-1:0]   port_size = '0;
  logic [NP*DW-1:0]  port_din = '0;
  logic [NP-1:0]     port_ack;
  logic [NP-1:0]     port_rvalid;
  logic [DW-1:0]     port_dout;
  logic              mem_read, mem_write, mem_refresh;
  logic              mem_busy = 1'b0;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_din;
  logic [1:0]        mem_size;
  logic [DW-1:0]     mem_dout = '0;
  logic              refresh_overrun;

  vram_port_arbiter #(
    .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REFRESH_INTERVAL(RI)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .port_req(port_req), .port_wr(port_wr), .port_addr(port_addr),
    .port_size(port_size), .port_din(port_din),
    .port_ack(port_ack), .port_rvalid(port_rvalid), .port_dout(port_dout),
    .mem_read(mem_read), .mem_write(mem_write), .mem_refresh(mem_refresh),
    .mem_busy(mem_busy), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_size(mem_size), .mem_dout(mem_dout), .refresh_overrun(refresh_overrun)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (one record per in-flight access) ----------
  int unsigned m_k, m_last, j_port, j_phase;
  bit          m_pend, m_ovr, j_act, j_ref, j_wr, m_valid;
  logic [NP-1:0] e_ack, e_rv;
  logic          e_rd, e_wrs, e_rf;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_din, e_dout;
  logic [1:0]    e_size;

  task automatic model_reset();
    m_k = 0; m_last = NP - 1; m_pend = 0; m_ovr = 0;
    j_act = 0; j_ref = 0; j_wr = 0; j_port = 0; j_phase = 0;
    e_ack = '0; e_rv = '0; e_rd = 0; e_wrs = 0; e_rf = 0;
    e_addr = '0; e_din = '0; e_dout = '0; e_size = '0;
  endtask

  task automatic model_step();
    logic [NP-1:0] avail;
    bit expire, due, found;
    int unsigned p;
    avail = port_req & ~e_ack;
    e_ack = '0; e_rv = '0; e_rd = 0; e_wrs = 0; e_rf = 0;
    m_k++;
    expire = ((m_k % RI) == 0);
    if (expire && m_pend) m_ovr = 1;
    due = m_pend || expire;
    if (!j_act) begin
      if (!mem_busy && due) begin
        e_rf = 1; due = 0; j_act = 1; j_ref = 1; j_phase = 1;
      end else if (!mem_busy && avail != '0) begin
        found = 0; p = 0;
        for (int s = 1; s <= NP; s++) begin
          if (!found && avail[(m_last + s) % NP]) begin
            found = 1; p = (m_last + s) % NP;
          end
        end
        j_act = 1; j_ref = 0; j_port = p; j_wr = port_wr[p]; j_phase = 0; m_last = p;
        e_addr = port_addr[p*AW +: AW];
        e_din  = port_din[p*DW +: DW];
        e_size = port_size[p*2 +: 2];
        e_rd = !j_wr; e_wrs = j_wr;
      end
    end else if (j_phase == 0) begin
      j_phase = 1;
    end else if (j_phase == 1) begin
      if (mem_busy) j_phase = 2;
    end else if (!mem_busy) begin
      j_act = 0;
      if (!j_ref) begin
        e_ack[j_port] = 1;
        if (!j_wr) begin e_rv[j_port] = 1; e_dout = mem_dout; end
      end
    end
    m_pend = due;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!reset_n) model_reset(); else model_step();
      m_valid = 1;
      #1;
      chk("port_ack", port_ack, e_ack);
      chk("port_rvalid", port_rvalid, e_rv);
      chk("port_dout", port_dout, e_dout);
      chk("mem_read", mem_read, e_rd);
      chk("mem_write", mem_write, e_wrs);
      chk("mem_refresh", mem_refresh, e_rf);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_din", mem_din, e_din);
      chk("mem_size", mem_size, e_size);
      chk("refresh_overrun", refresh_overrun, m_ovr);
    end
  end

  // ---------------- clients + memory controller, stepped on negedges -----------
  int unsigned lat = 3, bcnt = 0, cyc_n = 0, rd_cnt = 0;
  int unsigned acks [NP];
  bit          rep  [NP];
  bit          ack_rv [NP];
  logic [DW-1:0] ack_dout;
  logic [AW-1:0] rd_addr;
  int          ack_log [$];
  int          ev [$];          // 0 = refresh strobe, 1 = port strobe
  logic [DW-1:0] ps_din [$];
  int unsigned rf_cyc [$];

  task automatic cyc();
    @(negedge clk);
    cyc_n++;
    for (int i = 0; i < NP; i++) begin
      if (port_ack[i]) begin
        acks[i]++; ack_log.push_back(i); ack_rv[i] = port_rvalid[i]; ack_dout = port_dout;
        if (!rep[i]) port_req[i] = 1'b0;
      end
    end
    if (mem_refresh) begin ev.push_back(0); rf_cyc.push_back(cyc_n); end
    if (mem_read || mem_write) begin ev.push_back(1); ps_din.push_back(mem_din); end
    if (mem_read) begin rd_cnt++; rd_addr = mem_addr; end
    if (!reset_n) begin
      mem_busy = 1'b0; bcnt = 0;
    end else if (mem_read || mem_write || mem_refresh) begin
      mem_busy = 1'b1; bcnt = (mem_refresh ? 2 : lat) - 1;
    end else if (bcnt > 0) begin
      bcnt--;
    end else begin
      mem_busy = 1'b0;
    end
  endtask

  task automatic wait_ack(input int port, input int unsigned target, input string nm);
    int unsigned n = 0;
    while (acks[port] < target && n < 200) begin cyc(); n++; end
    chk(nm, acks[port] >= target, 1);
  endtask

  task automatic drain();
    int unsigned n = 0;
    for (int i = 0; i < NP; i++) rep[i] = 0;
    while ((port_req != '0 || mem_busy) && n < 300) begin cyc(); n++; end
    chk("drain_timeout", port_req == '0, 1);
    repeat (8) cyc();
  endtask

  task automatic set_port(input int p, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [1:0] sz);
    port_wr[p] = wr;
    port_addr[p*AW +: AW] = a;
    port_din[p*DW +: DW] = d;
    port_size[p*2 +: 2] = sz;
  endtask

  initial begin
    int unsigned n, first_p, nrf;
    for (int i = 0; i < NP; i++) begin acks[i] = 0; rep[i] = 0; ack_rv[i] = 0; end
    repeat (2) cyc();
    #1;
    chk("reset_ack", port_ack, 0);
    chk("reset_addr", mem_addr, 0);
    chk("reset_strobes", {mem_read, mem_write, mem_refresh}, 0);
    reset_n = 1'b1;

    // Round robin: all four ports write continuously, data = port index.
    for (int i = 0; i < NP; i++) begin
      set_port(i, 1'b1, AW'(i * 256), DW'(i), 2'(i)); rep[i] = 1;
    end
    port_req = '1;
    n = 0;
    while (ack_log.size() < 5 && n < 200) begin cyc(); n++; end
    chk("rr_timeout", ack_log.size() >= 5, 1);
    if (ack_log.size() >= 5) begin
      for (int k = 0; k < 5; k++) begin
        chk($sformatf("rr_order%0d", k), ack_log[k], k % NP);
        chk($sformatf("rr_din%0d", k), ps_din[k], DW'(k % NP));
      end
    end
    drain();

    // Single port 0 read.
    rd_cnt = 0; ack_log.delete(); ev.delete();
    mem_dout = 32'hDEADBEEF;
    set_port(0, 1'b0, 17'h00123, 32'h0, 2'b10);
    port_req[0] = 1'b1;
    wait_ack(0, acks[0] + 1, "rd_timeout");
    chk("rd_strobes", rd_cnt, 1);
    chk("rd_addr", rd_addr, 17'h00123);
    chk("rd_rvalid_with_ack", ack_rv[0], 1);
    chk("rd_dout", ack_dout, 32'hDEADBEEF);
    mem_dout = 32'h0;
    repeat (4) cyc();
    chk("rd_dout_hold", port_dout, 32'hDEADBEEF);
    drain();

    // Idle: refresh every RI cycles, no overrun.
    rf_cyc.delete();
    repeat (80) cyc();
    chk("rf_count", rf_cyc.size() >= 4, 1);
    for (int k = 2; k < rf_cyc.size(); k++)
      chk($sformatf("rf_period%0d", k), rf_cyc[k] - rf_cyc[k-1], RI);
    chk("rf_no_overrun", refresh_overrun, 0);

    // Refresh expiry coincident with a port request.
    n = 0;
    while (((m_k + 1) % RI) != 0 && n < 40) begin cyc(); n++; end
    ev.delete();
    mem_dout = 32'hCAFEF00D;
    set_port(2, 1'b0, 17'h00200, 32'h0, 2'b01);
    port_req[2] = 1'b1;
    wait_ack(2, acks[2] + 1, "coinc_timeout");
    chk("coinc_events", ev.size() >= 2, 1);
    if (ev.size() >= 2) begin
      chk("coinc_first_refresh", ev[0], 0);
      chk("coinc_then_port", ev[1], 1);
    end
    drain();
    repeat (20) cyc();

    // Long port 1 access spanning two expiries -> overrun.
    n = 0;
    while (((m_k + 1) % RI) != 8 && n < 40) begin cyc(); n++; end
    ev.delete(); lat = 40;
    set_port(1, 1'b1, 17'h00100, 32'h11111111, 2'b11);
    port_req[1] = 1'b1;
    n = 0;
    while (ev.size() == 0 && n < 20) begin cyc(); n++; end
    lat = 3;
    set_port(3, 1'b1, 17'h00300, 32'h33333333, 2'b00);
    port_req[3] = 1'b1;
    wait_ack(3, acks[3] + 1, "ovr_timeout");
    chk("ovr_sticky", refresh_overrun, 1);
    first_p = 0; nrf = 0;
    for (int k = 0; k < ev.size(); k++) begin
      if (ev[k] == 1) first_p++;
      else if (first_p == 1) nrf++;
    end
    chk("ovr_port_strobes", first_p, 2);
    chk("ovr_one_refresh_between", nrf, 1);
    drain();

    // Asynchronous reset while an access sits in WAIT_DONE.
    lat = 10; ev.delete();
    set_port(1, 1'b0, 17'h00100, 32'h0, 2'b01);
    port_req[1] = 1'b1;
    n = 0;
    while (ev.size() == 0 && n < 40) begin cyc(); n++; end
    repeat (5) cyc();
    reset_n = 1'b0;
    port_req = '0;
    #1;
    chk("arst_ack", port_ack, 0);
    chk("arst_dout", port_dout, 0);
    chk("arst_addr", mem_addr, 0);
    chk("arst_din", mem_din, 0);
    chk("arst_overrun", refresh_overrun, 0);
    repeat (2) cyc();
    reset_n = 1'b1;
    lat = 3; ack_log.delete();
    for (int i = 0; i < NP; i++) acks[i] = 0;
    set_port(0, 1'b0, 17'h00000, 32'h0, 2'b00);
    set_port(2, 1'b0, 17'h00200, 32'h0, 2'b00);
    mem_dout = 32'h5A5A5A5A;
    port_req[0] = 1'b1; port_req[2] = 1'b1;
    wait_ack(2, 1, "post_rst_timeout");
    chk("post_rst_first_grant", ack_log.size() > 0 ? ack_log[0] : -1, 0);
    chk("post_rst_no_stale", acks[1], 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
